// File: rtl/gpio_event_capture_if.sv
// gpio_event_capture_if: input bus, event stream and status bundle of the event capture block
interface gpio_event_capture_if #(
  parameter int Width = 32,
  parameter int Depth = 8,
  parameter int TsW   = 16
);
  localparam int LW = $clog2(Depth) + 1;
  logic [Width-1:0] data_in;
  logic [Width-1:0] cap_en;
  logic             ovf_clr;
  logic             evt_valid;
  logic             evt_ready;
  logic [TsW-1:0]   evt_ts;
  logic [Width-1:0] evt_mask;
  logic [Width-1:0] evt_level;
  logic [LW-1:0]    level;
  logic             ovf;
  logic [7:0]       drop_cnt;
  modport master (
    input  data_in, cap_en, ovf_clr, evt_ready,
    output evt_valid, evt_ts, evt_mask, evt_level, level, ovf, drop_cnt
  );
  modport slave (
    output data_in, cap_en, ovf_clr, evt_ready,
    input  evt_valid, evt_ts, evt_mask, evt_level, level, ovf, drop_cnt
  );
endinterface

// File: rtl/gpio_event_capture.sv
// gpio_event_capture: timestamps per-pin input transitions into a FIFO with overflow tracking
module gpio_event_capture #(
  parameter int Width = 32,
  parameter int Depth = 8,
  parameter int TsW   = 16
) (
  input logic clk_i,
  input logic rst_ni,
  gpio_event_capture_if.master bus
);
  localparam int AW = $clog2(Depth);
  localparam int LW = AW + 1;
  logic [TsW-1:0]   ts;
  logic [Width-1:0] prev, chg;
  logic             primed;
  logic [TsW-1:0]   mem_ts   [Depth];
  logic [Width-1:0] mem_mask [Depth];
  logic [Width-1:0] mem_lvl  [Depth];
  logic [AW-1:0]    wp, rp;
  logic [LW-1:0]    cnt;
  logic             ovf;
  logic [7:0]       drop_cnt;
  logic             full, pop, push, drop;
  always_comb begin
    chg  = primed ? (bus.data_in ^ prev) & bus.cap_en : '0;
    full = cnt == LW'(Depth);
    pop  = (cnt != '0) & bus.evt_ready;
    push = (|chg) & (!full | pop);
    drop = (|chg) & full & !pop;
  end
  // storage needs no reset: pointers and count define which entries are live
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_ts[wp]   <= ts;
      mem_mask[wp] <= chg;
      mem_lvl[wp]  <= bus.data_in;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ts       <= '0;
      prev     <= '0;
      primed   <= 1'b0;
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      ts       <= ts + TsW'(1);
      prev     <= bus.data_in;
      primed   <= 1'b1;
      wp       <= push ? wp + AW'(1) : wp;
      rp       <= pop ? rp + AW'(1) : rp;
      cnt      <= cnt + LW'(push) - LW'(pop);
      ovf      <= bus.ovf_clr ? 1'b0 : ovf | drop;
      drop_cnt <= bus.ovf_clr ? 8'd0 : (drop && drop_cnt != 8'hFF) ? drop_cnt + 8'd1 : drop_cnt;
    end
  end
  assign bus.evt_valid = cnt != '0;
  assign bus.evt_ts    = mem_ts[rp];
  assign bus.evt_mask  = mem_mask[rp];
  assign bus.evt_level = mem_lvl[rp];
  assign bus.level     = cnt;
  assign bus.ovf       = ovf;
  assign bus.drop_cnt  = drop_cnt;
endmodule

// File: tb/tb_gpio_event_capture.sv
// tb_gpio_event_capture: directed and random stimulus checked against a queue-based reference model
module tb_gpio_event_capture;
  localparam int W = 32;
  localparam int DEPTH = 8;
  localparam int TSW = 4;
  typedef struct {
    logic [TSW-1:0] ts;
    logic [W-1:0]   mask;
    logic [W-1:0]   lvl;
  } rec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  gpio_event_capture_if #(.Width(W), .Depth(DEPTH), .TsW(TSW)) bus ();
  gpio_event_capture #(.Width(W), .Depth(DEPTH), .TsW(TSW)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  rec_t     q[$];
  int       cyc = 0;
  bit       primed = 0;
  logic [W-1:0] prev = '0;
  bit       m_ovf = 0;
  int       m_drops = 0;
  int       n_chk = 0;
  int       n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("valid", 64'(bus.evt_valid), 64'(q.size() > 0));
    chk("level", 64'(bus.level), 64'(q.size()));
    chk("ovf", 64'(bus.ovf), 64'(m_ovf));
    chk("drop_cnt", 64'(bus.drop_cnt), 64'(m_drops));
    if (q.size() > 0) begin
      chk("head_ts", 64'(bus.evt_ts), 64'(q[0].ts));
      chk("head_mask", 64'(bus.evt_mask), 64'(q[0].mask));
      chk("head_lvl", 64'(bus.evt_level), 64'(q[0].lvl));
    end
  endtask
  // model advances on the same edge the DUT samples its inputs, then outputs are compared 1 time unit later
  task automatic tick();
    logic [W-1:0] chg;
    bit popd, dropped;
    if (!rst_n) begin
      q.delete();
      cyc = 0; primed = 0; prev = '0; m_ovf = 0; m_drops = 0;
    end else begin
      chg = primed ? (bus.data_in ^ prev) & bus.cap_en : '0;
      popd = q.size() > 0 && bus.evt_ready;
      dropped = 0;
      if (chg != '0) begin
        if (q.size() < DEPTH || popd) q.push_back('{TSW'(cyc % (1 << TSW)), chg, bus.data_in});
        else dropped = 1;
      end
      if (popd) void'(q.pop_front());
      m_ovf = bus.ovf_clr ? 0 : (m_ovf | dropped);
      m_drops = bus.ovf_clr ? 0 : (dropped && m_drops < 255) ? m_drops + 1 : m_drops;
      prev = bus.data_in; primed = 1; cyc++;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic toggle(input int b);
    bus.data_in = bus.data_in ^ (W'(1) << b);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.data_in = 32'hFFFF_0000; bus.cap_en = '1; bus.ovf_clr = 0; bus.evt_ready = 0;
    tick(); tick();
    chk("rst_level", 64'(bus.level), 64'd0);
    rst_n = 1;
    for (int i = 0; i < 10; i++) tick();
    chk("prime_valid", 64'(bus.evt_valid), 64'd0);
    rst_n = 0; tick(); rst_n = 1;
    while (cyc != 5) tick();
    bus.data_in = bus.data_in | 32'h9;
    tick();
    chk("two_bit_valid", 64'(bus.evt_valid), 64'd1);
    chk("two_bit_ts", 64'(bus.evt_ts), 64'd5);
    chk("two_bit_mask", 64'(bus.evt_mask), 64'h9);
    chk("two_bit_lvl", 64'(bus.evt_level), 64'hFFFF_0009);
    bus.evt_ready = 1; tick(); bus.evt_ready = 0;
    bus.cap_en = 32'h1;
    toggle(1); tick();
    toggle(0); tick();
    chk("mask_en_level", 64'(bus.level), 64'd1);
    chk("mask_en_mask", 64'(bus.evt_mask), 64'h1);
    bus.evt_ready = 1; tick(); bus.evt_ready = 0;
    bus.cap_en = '1;
    for (int i = 0; i < 10; i++) begin toggle(i + 4); tick(); end
    chk("ovf_level", 64'(bus.level), 64'd8);
    chk("ovf_flag", 64'(bus.ovf), 64'd1);
    chk("ovf_drops", 64'(bus.drop_cnt), 64'd2);
    bus.evt_ready = 1;
    for (int i = 0; i < 8; i++) tick();
    bus.evt_ready = 0;
    bus.ovf_clr = 1; tick(); bus.ovf_clr = 0;
    chk("clr_ovf", 64'(bus.ovf), 64'd0);
    chk("clr_drops", 64'(bus.drop_cnt), 64'd0);
    for (int i = 0; i < 8; i++) begin toggle(i + 16); tick(); end
    toggle(30); bus.evt_ready = 1; tick(); bus.evt_ready = 0;
    chk("full_pop_level", 64'(bus.level), 64'd8);
    chk("full_pop_ovf", 64'(bus.ovf), 64'd0);
    for (int i = 0; i < 300; i++) begin toggle(i % W); tick(); end
    chk("sat_drops", 64'(bus.drop_cnt), 64'd255);
    toggle(2); bus.ovf_clr = 1; tick(); bus.ovf_clr = 0;
    chk("clr_wins_ovf", 64'(bus.ovf), 64'd0);
    chk("clr_wins_drops", 64'(bus.drop_cnt), 64'd0);
    bus.evt_ready = 1;
    for (int i = 0; i < 9; i++) tick();
    bus.evt_ready = 0;
    rst_n = 0; tick(); rst_n = 1;
    while (cyc != 15) tick();
    toggle(5); tick(); tick();
    toggle(6); tick();
    chk("wrap_ts0", 64'(bus.evt_ts), 64'd15);
    bus.evt_ready = 1; tick(); bus.evt_ready = 0;
    chk("wrap_ts1", 64'(bus.evt_ts), 64'd1);
    toggle(7); tick(); toggle(8); tick();
    chk("pre_rst_level", 64'(bus.level), 64'd3);
    rst_n = 0; tick();
    chk("mid_rst_level", 64'(bus.level), 64'd0);
    chk("mid_rst_valid", 64'(bus.evt_valid), 64'd0);
    rst_n = 1; tick();
    toggle(9); tick();
    chk("post_rst_ts", 64'(bus.evt_ts), 64'd1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom % 3 == 0) bus.data_in = bus.data_in ^ ($urandom & $urandom & $urandom);
      bus.cap_en = ($urandom % 4 == 0) ? $urandom : '1;
      bus.evt_ready = $urandom % 3 == 0;
      bus.ovf_clr = $urandom % 40 == 0;
      rst_n = $urandom % 200 != 0;
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
